md_unit_seq: RTL and testbench
==============================

// Module: md_unit_seq
// PURPOSE
//   Parametrised iterative multiply/divide unit for the E stage; replaces the fixed-latency HI/LO block.
//   Computes mult/multu/div/divu/madd/maddu with a real shift-add multiplier and restoring divider (one bit per cycle).
//   Handles mthi/mtlo and writes HI/LO only on completion.
//   Flush aborts an in-flight op on exception/branch kill without touching HI/LO.
// PARAMETERS
//   WIDTH  32  operand width and width of each of HI and LO
//   CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   CLK      in   1      clock, rising edge
//   Reset    in   1      asynchronous, active-low reset (0 = reset)
//   Start    in   1      launch op selected by MDSel; sampled on rising edge
//   MDSel    in   4      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu
//   OprandA  in   WIDTH  rs operand (forwarded value)
//   OprandB  in   WIDTH  rt operand (forwarded value)
//   Flush    in   1      abort current op; sampled on rising edge
//   HI       out  WIDTH  architectural HI
//   LO       out  WIDTH  architectural LO
//   Busy     out  1      op in flight; D stage stalls mf/mt/md instrs while high
//   Done     out  1      one-cycle pulse on the cycle after HI/LO update
// BEHAVIOUR
//   Reset=0 (async): state IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0, internal regs cleared.
//     Applies immediately, including mid-op; op is lost.
//   States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE, Start=1, Flush=0, MDSel in {1,2,3,4,7,8}:
//     Latch |A|,|B| (signed ops) or A,B (unsigned ops) and result signs; go to CALC; counter=WIDTH.
//   CALC: one multiplier add/shift or divider subtract/restore step per cycle; counter decrements.
//     Leaves CALC when counter reaches 1.
//   FIX (1 cycle): negate magnitudes as required, then write HI/LO at the FIX->IDLE edge.
//     mult/multu: {HI,LO} = 2*WIDTH-bit product.
//     madd/maddu: {HI,LO} = {HI,LO} + product, modulo 2**(2*WIDTH); HI/LO are those held at the Start edge.
//     div/divu: LO = quotient, HI = remainder.
//       Signed: quotient truncates toward zero; remainder takes dividend's sign.
//   Latency: Busy high for exactly WIDTH+1 cycles after the Start edge.
//     HI/LO update on the edge that drops Busy.
//     Done=1 for the following single cycle.
//   Divide by zero (B==0, div or divu): LO = all ones, HI = OprandA as latched; same latency; no error flag.
//   Signed overflow (div, A=min negative, B=-1): LO = min negative (0x80000000 at WIDTH=32), HI = 0.
//   IDLE, Start=1, MDSel=5/6: HI/LO = OprandA at that edge; Busy stays 0; Done stays 0.
//   Start with MDSel=0 or 9..15: no effect.
//   Start while Busy=1: ignored; current op continues unchanged.
//   Flush=1 in CALC/FIX: return to IDLE at that edge; Busy=0 next cycle; HI/LO keep pre-op values; no Done.
//   Flush=1 in IDLE: no effect. Flush and Start on the same edge: Flush wins; Start is dropped.
//   OprandA/B may change after the Start edge; the unit works only from latched copies.
// TESTING
//   Reset low mid-CALC (cycle 10 of a div) -> HI=LO=0, Busy=0 immediately; no Done after release.
//   mult A=0xFFFFFFFE, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy high 33 cycles; Done pulses at cycle 34.
//   multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//   div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
//   div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
//   mtlo 5, mthi 1, then maddu A=B=0xFFFFFFFF -> HI=0xFFFFFFFF, LO=0x00000006.
//   divu started, Flush at cycle 12, Start held during Busy -> HI/LO unchanged, Busy=0 next cycle, no Done.
//     Start held while Busy never relaunches the op.

Source files
------------

// File: rtl/md_unit_seq_if.sv
// Request/result bundle between the E stage and the iterative multiply/divide unit.
// The E stage drives the request side; the unit returns HI/LO and its status.
interface md_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       MDSel;
    logic [WIDTH-1:0] OprandA;
    logic [WIDTH-1:0] OprandB;
    logic             Flush;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MDSel, OprandA, OprandB, Flush,
        input  HI, LO, Busy, Done
    );

    modport slave (
        input  Start, MDSel, OprandA, OprandB, Flush,
        output HI, LO, Busy, Done
    );
endinterface

// File: rtl/md_unit_seq.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider, one bit per
// cycle, with HI/LO written only when an operation completes.
//
//   state | meaning
//   IDLE  | waiting for Start; mthi/mtlo are handled here in a single cycle
//   CALC  | one multiply or divide step per cycle, counter runs WIDTH..1
//   FIX   | apply result signs / accumulate, write HI/LO on the exit edge
module md_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          CLK,
    input  logic          Reset,
    md_unit_seq_if.slave  md
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    localparam logic [3:0] SEL_MULT  = 4'd1;
    localparam logic [3:0] SEL_MULTU = 4'd2;
    localparam logic [3:0] SEL_DIV   = 4'd3;
    localparam logic [3:0] SEL_DIVU  = 4'd4;
    localparam logic [3:0] SEL_MTHI  = 4'd5;
    localparam logic [3:0] SEL_MTLO  = 4'd6;
    localparam logic [3:0] SEL_MADD  = 4'd7;
    localparam logic [3:0] SEL_MADDU = 4'd8;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mcand_q;
    logic                 div_q, acc_q, neg_q, rneg_q, div0_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    logic                 busy, wr_hilo;
    logic                 is_mul, is_div, is_sgn, is_acc, launch, idle_req;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    always_comb begin
        is_mul = (md.MDSel == SEL_MULT) || (md.MDSel == SEL_MULTU) ||
                 (md.MDSel == SEL_MADD) || (md.MDSel == SEL_MADDU);
        is_div = (md.MDSel == SEL_DIV)  || (md.MDSel == SEL_DIVU);
        is_sgn = (md.MDSel == SEL_MULT) || (md.MDSel == SEL_DIV) || (md.MDSel == SEL_MADD);
        is_acc = (md.MDSel == SEL_MADD) || (md.MDSel == SEL_MADDU);
        idle_req = (state_q == IDLE) && md.Start && !md.Flush;
        launch   = idle_req && (is_mul || is_div);
        a_neg = is_sgn && md.OprandA[WIDTH-1];
        b_neg = is_sgn && md.OprandB[WIDTH-1];
        a_mag = a_neg ? (~md.OprandA + 1'b1) : md.OprandA;
        b_mag = b_neg ? (~md.OprandB + 1'b1) : md.OprandB;
    end

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = CALC;
            CALC: begin
                if (md.Flush)                        state_d = IDLE;
                else if (cnt_q == CNT_W'(1))         state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (state_q != IDLE);
        wr_hilo = (state_q == FIX) && !md.Flush;
    end

    // Datapath: prod_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]       mul_sum, div_sh, div_trial;
    logic [2*WIDTH-1:0]   mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        div_sh    = prod_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_sh - {1'b0, mcand_q};
        div_next  = div_trial[WIDTH] ? {div_sh[WIDTH-1:0],    prod_q[WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0]   prod_s, mul_res;
    logic [WIDTH-1:0]     quo_s, rem_s, res_hi, res_lo;

    always_comb begin
        prod_s  = neg_q ? (~prod_q + 1'b1) : prod_q;
        mul_res = acc_q ? ({hi_q, lo_q} + prod_s) : prod_s;
        quo_s   = neg_q  ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
        rem_s   = rneg_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];
        if (div_q) begin
            // With a zero divisor the remainder is |A| restored to A's sign, i.e. A itself
            res_hi = rem_s;
            res_lo = div0_q ? '1 : quo_s;
        end else begin
            res_hi = mul_res[2*WIDTH-1:WIDTH];
            res_lo = mul_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            div_q   <= 1'b0;
            acc_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else if (launch) begin
            cnt_q   <= CNT_W'(WIDTH);
            prod_q  <= {{WIDTH{1'b0}}, a_mag};
            mcand_q <= b_mag;
            div_q   <= is_div;
            acc_q   <= is_acc;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            div0_q  <= (md.OprandB == '0);
        end else if (state_q == CALC && !md.Flush) begin
            cnt_q  <= cnt_q - 1'b1;
            prod_q <= div_q ? div_next : mul_next;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= wr_hilo;
            if (wr_hilo) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (idle_req && md.MDSel == SEL_MTHI) begin
                hi_q <= md.OprandA;
            end else if (idle_req && md.MDSel == SEL_MTLO) begin
                lo_q <= md.OprandA;
            end
        end
    end

    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
    assign md.Busy = busy;
    assign md.Done = done_q;

endmodule

// File: tb/tb_md_unit_seq.sv
// Directed bench for md_unit_seq: hand-computed HI/LO results, latency, flush and reset behaviour.
module tb_md_unit_seq;
    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_err;

    md_unit_seq_if #(.WIDTH(32)) mif ();

    md_unit_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .md    (mif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Launch a timed op, scramble operands after the Start edge, count Busy cycles.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output logic done_after);
        mif.Start = 1'b1; mif.MDSel = sel; mif.OprandA = a; mif.OprandB = b;
        step();
        mif.Start = 1'b0; mif.MDSel = 4'd0;
        mif.OprandA = 32'hDEADBEEF; mif.OprandB = 32'h0BADF00D;
        busy_n = 0;
        while (mif.Busy && busy_n < 100) begin
            busy_n++;
            step();
        end
        done_after = mif.Done;
    endtask

    task automatic do_mt(input logic [3:0] sel, input logic [31:0] a);
        mif.Start = 1'b1; mif.MDSel = sel; mif.OprandA = a; mif.OprandB = 32'h0;
        step();
        mif.Start = 1'b0; mif.MDSel = 4'd0; mif.OprandA = 32'hDEADBEEF;
    endtask

    task automatic timed(input string tag, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   bn;
        logic dn;
        do_op(sel, a, b, bn, dn);
        chk({tag, "_busy_cycles"}, 32'(bn), 32'd33);
        chk({tag, "_done"}, {31'd0, dn}, 32'd1);
        chk({tag, "_hi"}, mif.HI, exp_hi);
        chk({tag, "_lo"}, mif.LO, exp_lo);
        step();
        chk({tag, "_done_one_cycle"}, {31'd0, mif.Done}, 32'd0);
    endtask

    initial begin
        int dn_cnt;
        n_checks = 0;
        n_err    = 0;
        Reset = 1'b0;
        mif.Start = 1'b0; mif.MDSel = 4'd0; mif.Flush = 1'b0;
        mif.OprandA = 32'h0; mif.OprandB = 32'h0;
        #12;
        chk("reset_hi", mif.HI, 32'h0);
        chk("reset_lo", mif.LO, 32'h0);
        chk("reset_busy", {31'd0, mif.Busy}, 32'd0);
        chk("reset_done", {31'd0, mif.Done}, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        step();

        // mthi / mtlo take effect immediately, no Busy, no Done
        do_mt(4'd5, 32'h12345678);
        chk("mthi_hi", mif.HI, 32'h12345678);
        chk("mthi_busy", {31'd0, mif.Busy}, 32'd0);
        chk("mthi_done", {31'd0, mif.Done}, 32'd0);
        do_mt(4'd6, 32'h9ABCDEF0);
        chk("mtlo_lo", mif.LO, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", mif.HI, 32'h12345678);

        // Async reset in cycle 10 of a div
        mif.Start = 1'b1; mif.MDSel = 4'd3; mif.OprandA = 32'hFFFFFFF9; mif.OprandB = 32'd2;
        step();
        mif.Start = 1'b0; mif.MDSel = 4'd0;
        repeat (9) step();
        chk("rst_mid_busy_before", {31'd0, mif.Busy}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("rst_mid_hi", mif.HI, 32'h0);
        chk("rst_mid_lo", mif.LO, 32'h0);
        chk("rst_mid_busy", {31'd0, mif.Busy}, 32'd0);
        step();
        Reset = 1'b1;
        dn_cnt = 0;
        repeat (40) begin
            step();
            if (mif.Done || mif.Busy) dn_cnt++;
        end
        chk("rst_mid_no_done", 32'(dn_cnt), 32'd0);

        timed("mult",     4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        timed("multu",    4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA);
        timed("div_n7_2", 4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        timed("div_7_n2", 4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        timed("divu_100_7", 4'd4, 32'd100,    32'd7,        32'h00000002, 32'h0000000E);
        timed("divu_by0", 4'd4, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
        timed("div_by0_neg", 4'd3, 32'hFFFFFFF9, 32'd0,     32'hFFFFFFF9, 32'hFFFFFFFF);
        timed("div_ovf",  4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        do_mt(4'd6, 32'd5);
        do_mt(4'd5, 32'd1);
        timed("maddu",    4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000006);
        timed("madd",     4'd7, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'h00000000);

        // Reserved selectors and Flush-vs-Start in IDLE have no effect
        do_mt(4'd0, 32'h55555555);
        do_mt(4'd9, 32'h55555555);
        chk("nop_busy", {31'd0, mif.Busy}, 32'd0);
        chk("nop_hi", mif.HI, 32'hFFFFFFFF);
        chk("nop_lo", mif.LO, 32'h00000000);
        mif.Flush = 1'b1;
        do_mt(4'd5, 32'h77777777);
        mif.Flush = 1'b0;
        chk("flush_drops_mthi", mif.HI, 32'hFFFFFFFF);

        // Flush at cycle 12 of a divu with Start held while Busy
        mif.Start = 1'b1; mif.MDSel = 4'd4; mif.OprandA = 32'd100; mif.OprandB = 32'd7;
        step();
        mif.MDSel = 4'd2; mif.OprandA = 32'd5; mif.OprandB = 32'd5;
        repeat (11) step();
        chk("flush_busy_before", {31'd0, mif.Busy}, 32'd1);
        mif.Flush = 1'b1;
        step();
        mif.Flush = 1'b0; mif.Start = 1'b0; mif.MDSel = 4'd0;
        chk("flush_busy", {31'd0, mif.Busy}, 32'd0);
        chk("flush_hi", mif.HI, 32'hFFFFFFFF);
        chk("flush_lo", mif.LO, 32'h00000000);
        dn_cnt = 0;
        repeat (40) begin
            step();
            if (mif.Done || mif.Busy) dn_cnt++;
        end
        chk("flush_no_done", 32'(dn_cnt), 32'd0);
        chk("flush_hi_after", mif.HI, 32'hFFFFFFFF);
        chk("flush_lo_after", mif.LO, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
